// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with valid/ready on both sides,
// redirect flush, and a saturating counter of downstream back-pressure cycles.
module pipe_stage_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             stall_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]    FULL      = CW'(DEPTH);
    localparam logic [PW-1:0]    LAST      = PW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    generate
        if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
            $error("pipe_stage_fifo: DEPTH must be in 1..16");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             push, pop;

    // s_ready is a register so that m_ready never reaches s_ready combinationally.
    assign s_ready   = ready_q;
    assign m_valid   = (count_q != '0);
    assign m_data    = mem[rd_ptr_q];
    assign count     = count_q;
    assign stall_cnt = stall_q;

    assign push = s_valid & ready_q;
    assign pop  = m_valid & m_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;

        if (m_valid && !m_ready && !flush && stall_q != STALL_MAX) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end

        ready_d = (count_d != FULL);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            stall_q  <= stall_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && push && !flush) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo: three instances (DEPTH=2, DEPTH=3, CNT_W=4) share one clock.
module tb_pipe_stage_fifo;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        a_rst, a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [31:0] a_s_data, a_m_data;
    logic [1:0]  a_count;
    logic [15:0] a_stall;

    logic        b_rst, b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [31:0] b_s_data, b_m_data;
    logic [1:0]  b_count;
    logic [15:0] b_stall;

    logic        c_rst, c_flush, c_s_valid, c_s_ready, c_m_valid, c_m_ready;
    logic [31:0] c_s_data, c_m_data;
    logic [1:0]  c_count;
    logic [3:0]  c_stall;

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .count(a_count), .stall_cnt(a_stall)
    );

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .count(b_count), .stall_cnt(b_stall)
    );

    pipe_stage_fifo #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) u_c (
        .clk(clk), .rst(c_rst), .flush(c_flush),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
        .count(c_count), .stall_cnt(c_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 0; a_flush = 0; a_s_valid = 0; a_m_ready = 0; a_s_data = '0;
        b_rst = 0; b_flush = 0; b_s_valid = 0; b_m_ready = 0; b_s_data = '0;
        c_rst = 0; c_flush = 0; c_s_valid = 0; c_m_ready = 0; c_s_data = '0;
        step();
        step();

        // Reset state
        check("rst_s_ready", 32'(a_s_ready), 32'd0);
        check("rst_m_valid", 32'(a_m_valid), 32'd0);
        check("rst_count",   32'(a_count),   32'd0);
        check("rst_stall",   32'(a_stall),   32'd0);
        a_rst = 1; b_rst = 1; c_rst = 1;
        step();
        check("rel_s_ready_a", 32'(a_s_ready), 32'd1);
        check("rel_s_ready_b", 32'(b_s_ready), 32'd1);

        // 1. Streaming with m_ready=1
        a_m_ready = 1;
        a_s_valid = 1; a_s_data = 32'h11;
        step();
        check("t1_data0",  a_m_data,        32'h11);
        check("t1_count0", 32'(a_count),    32'd1);
        a_s_data = 32'h22;
        step();
        check("t1_data1",  a_m_data,        32'h22);
        check("t1_count1", 32'(a_count),    32'd1);
        a_s_data = 32'h33;
        step();
        check("t1_data2",  a_m_data,        32'h33);
        check("t1_count2", 32'(a_count),    32'd1);
        a_s_valid = 0;
        step();
        check("t1_empty",  32'(a_m_valid),  32'd0);
        check("t1_stall",  32'(a_stall),    32'd0);

        // 2. Back-pressure
        a_m_ready = 0;
        a_s_valid = 1; a_s_data = 32'hA;
        step();
        check("t2_dataA",   a_m_data,         32'hA);
        check("t2_ready1",  32'(a_s_ready),   32'd1);
        a_s_data = 32'hB;
        step();
        check("t2_count2",  32'(a_count),     32'd2);
        check("t2_full",    32'(a_s_ready),   32'd0);
        check("t2_stall1",  32'(a_stall),     32'd1);
        a_s_data = 32'hC;
        step();
        check("t2_hold",    a_m_data,         32'hA);
        check("t2_count2b", 32'(a_count),     32'd2);
        check("t2_stall2",  32'(a_stall),     32'd2);
        a_m_ready = 1;
        step();
        check("t2_dataB",   a_m_data,         32'hB);
        check("t2_ready",   32'(a_s_ready),   32'd1);
        step();
        check("t2_dataC",   a_m_data,         32'hC);
        a_s_valid = 0;
        step();
        check("t2_empty",   32'(a_m_valid),   32'd0);
        check("t2_stallF",  32'(a_stall),     32'd2);

        // 4a. Flush with count=1, stalled head and an accepted push: push dropped, stall held
        a_m_ready = 0;
        a_s_valid = 1; a_s_data = 32'h88;
        step();
        check("t4a_count1", 32'(a_count),     32'd1);
        a_s_data = 32'h55; a_flush = 1;
        step();
        check("t4a_count0", 32'(a_count),     32'd0);
        check("t4a_mvalid", 32'(a_m_valid),   32'd0);
        check("t4a_stall",  32'(a_stall),     32'd2);
        check("t4a_ready",  32'(a_s_ready),   32'd1);
        a_flush = 0; a_s_valid = 0;
        step();
        check("t4a_drop",   32'(a_count),     32'd0);

        // 4b. Flush with count=2 while head pops
        a_s_valid = 1; a_s_data = 32'h66;
        step();
        a_s_data = 32'h77;
        step();
        check("t4b_count2", 32'(a_count),     32'd2);
        check("t4b_stall3", 32'(a_stall),     32'd3);
        a_s_data = 32'h55; a_flush = 1; a_m_ready = 1;
        step();
        check("t4b_count0", 32'(a_count),     32'd0);
        check("t4b_mvalid", 32'(a_m_valid),   32'd0);
        a_flush = 0; a_s_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4b_no55", 32'(a_m_valid), 32'd0);
        end
        a_m_ready = 0;
        a_s_valid = 1; a_s_data = 32'h99;
        step();
        check("t4b_after",  a_m_data,         32'h99);
        check("t4b_cnt1",   32'(a_count),     32'd1);
        check("t4b_stall",  32'(a_stall),     32'd3);

        // 5. Mid-stream reset
        a_s_valid = 0;
        a_rst = 0;
        step();
        check("t5_count",   32'(a_count),     32'd0);
        check("t5_mvalid",  32'(a_m_valid),   32'd0);
        check("t5_sready",  32'(a_s_ready),   32'd0);
        check("t5_stall",   32'(a_stall),     32'd0);
        a_rst = 1;
        step();
        check("t5_sready1", 32'(a_s_ready),   32'd1);
        check("t5_count1",  32'(a_count),     32'd0);

        // 3. DEPTH=3: full, push+pop cycle, then wrap over 10 beats
        b_m_ready = 0; b_s_valid = 1;
        for (int v = 1; v <= 3; v++) begin
            b_s_data = 32'(v);
            step();
        end
        check("t3_full_cnt", 32'(b_count),    32'd3);
        check("t3_full_rdy", 32'(b_s_ready),  32'd0);
        b_s_data = 32'd4; b_m_ready = 1;
        check("t3_pp_rdy",   32'(b_s_ready),  32'd0);
        step();
        check("t3_cnt2",     32'(b_count),    32'd2);
        check("t3_rdy_up",   32'(b_s_ready),  32'd1);
        check("t3_head2",    b_m_data,        32'd2);
        for (int v = 4; v <= 10; v++) begin
            b_s_data = 32'(v);
            step();
            check("t3_order", b_m_data, 32'(v - 1));
            check("t3_cnt",   32'(b_count), 32'd2);
        end
        b_s_valid = 0;
        step();
        check("t3_last",     b_m_data,        32'd10);
        step();
        check("t3_empty",    32'(b_m_valid),  32'd0);

        // 6. CNT_W=4 saturation
        c_m_ready = 0; c_s_valid = 1; c_s_data = 32'h5;
        step();
        check("t6_start",    32'(c_stall),    32'd0);
        c_s_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) check("t6_k14", 32'(c_stall), 32'd14);
            if (k == 15) check("t6_k15", 32'(c_stall), 32'd15);
            if (k == 20) check("t6_k20", 32'(c_stall), 32'd15);
        end
        check("t6_head",     c_m_data,        32'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
